// File: rtl/move_scheduler.sv
// move_scheduler: arbitrates move requests from the scanner (A) and the
// solver (B), drives one move at a time to the motor driver, waits for
// completion plus a settle interval, then acknowledges the owner.
// Optional feature macro: ARB_RR_EN -- when defined, simultaneous requests
// alternate between A and B; when undefined, A wins every tie.
module move_scheduler #(
  parameter logic [15:0] SETTLE_CYCLES  = 16'd50000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_a,
  input  logic [4:0]  move_a,
  input  logic        req_b,
  input  logic [4:0]  move_b,
  input  logic        motor_done,
  output logic        ack_a,
  output logic        ack_b,
  output logic        err,
  output logic [4:0]  motor_move,
  output logic        motor_start,
  output logic        sensor_stable,
  output logic        busy,
  output logic        grant,
  output logic [15:0] moves_issued
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    SETTLE = 3'd3,
    ACK    = 3'd4,
    GAP    = 3'd5
  } state_t;

  // Move codes 0..17 are the 18 face turns; anything above is garbage.
  function automatic logic code_is_valid(input logic [4:0] code);
    return (code <= 5'd17);
  endfunction

  state_t      r_state;
  logic [23:0] r_cnt;
  logic [4:0]  r_move;
  logic        r_grant;
  logic        r_busy;
  logic        r_start;
  logic        r_ack_a;
  logic        r_ack_b;
  logic        r_err;
  logic        r_stable;
  logic        r_fail;
  logic [15:0] r_moves;
`ifdef ARB_RR_EN
  logic        r_rr_b;   // 1: B is favoured on the next tie
`endif

  logic        w_pick_b;
  logic [4:0]  w_win_move;
  logic        w_settle_last;
  logic        w_timeout_last;

  // Pick the winner among pending requesters; ties resolved by the arbiter mode.
  always_comb begin
    w_pick_b = 1'b0;
    if (req_a && req_b) begin
`ifdef ARB_RR_EN
      w_pick_b = r_rr_b;
`else
      w_pick_b = 1'b0;
`endif
    end else if (req_b) begin
      w_pick_b = 1'b1;
    end else begin
      w_pick_b = 1'b0;
    end
  end

  assign w_win_move     = w_pick_b ? move_b : move_a;
  // The counter restarts at zero on entry to WAIT/SETTLE, so the state's
  // final cycle is the one where cnt+1 reaches the limit.
  assign w_settle_last  = ((r_cnt + 24'd1) >= {8'd0, SETTLE_CYCLES});
  assign w_timeout_last = ((r_cnt + 24'd1) >= TIMEOUT_CYCLES);

  // Transaction FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 24'd0;
      r_move   <= 5'd0;
      r_grant  <= 1'b0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_err    <= 1'b0;
      r_stable <= 1'b0;
      r_fail   <= 1'b0;
      r_moves  <= 16'd0;
`ifdef ARB_RR_EN
      r_rr_b   <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_a || req_b) begin
            r_move   <= w_win_move;
            r_grant  <= w_pick_b;
            r_busy   <= 1'b1;
            r_stable <= 1'b0;
            // An invalid code never reaches the motor.
            r_start  <= code_is_valid(w_win_move);
            r_state  <= ISSUE;
`ifdef ARB_RR_EN
            r_rr_b   <= ~w_pick_b;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          // motor_done is deliberately not looked at here.
          r_cnt <= 24'd0;
          if (!code_is_valid(r_move)) begin
            r_fail  <= 1'b1;
            r_err   <= 1'b1;
            r_ack_a <= ~r_grant;
            r_ack_b <= r_grant;
            r_state <= ACK;
          end else begin
            r_fail  <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (motor_done) begin
            r_cnt <= 24'd0;
            if (SETTLE_CYCLES == 16'd0) begin
              r_ack_a <= ~r_grant;
              r_ack_b <= r_grant;
              r_state <= ACK;
            end else begin
              r_state <= SETTLE;
            end
          end else if (w_timeout_last) begin
            r_fail  <= 1'b1;
            r_err   <= 1'b1;
            r_ack_a <= ~r_grant;
            r_ack_b <= r_grant;
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        SETTLE: begin
          if (w_settle_last) begin
            r_ack_a <= ~r_grant;
            r_ack_b <= r_grant;
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        ACK: begin
          if (!r_fail) begin
            r_stable <= 1'b1;
            if (r_moves != 16'hFFFF) begin
              r_moves <= r_moves + 16'd1;
            end else begin
              r_moves <= r_moves;
            end
          end else begin
            r_stable <= 1'b0;
          end
          r_state <= GAP;
        end
        GAP: begin
          // Dead cycle so the requester can drop req after seeing ack.
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack_a         = r_ack_a;
  assign ack_b         = r_ack_b;
  assign err           = r_err;
  assign motor_move    = r_move;
  assign motor_start   = r_start;
  assign sensor_stable = r_stable;
  assign busy          = r_busy;
  assign grant         = r_grant;
  assign moves_issued  = r_moves;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: instance m (settle 4, timeout 20) and
// instance t (settle 0, timeout 8). Cycle numbers in comments count from
// the cycle in which the request is first driven.
module tb_move_scheduler;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic        req_a, req_b, motor_done;
  logic [4:0]  move_a, move_b;
  logic        ack_a, ack_b, err, motor_start, sensor_stable, busy, grant;
  logic [4:0]  motor_move;
  logic [15:0] moves_issued;

  logic        t_req_a, t_req_b, t_motor_done;
  logic [4:0]  t_move_a, t_move_b;
  logic        t_ack_a, t_ack_b, t_err, t_motor_start, t_sensor_stable, t_busy, t_grant;
  logic [4:0]  t_motor_move;
  logic [15:0] t_moves_issued;

  int checks   = 0;
  int failures = 0;

`ifdef ARB_RR_EN
  localparam logic EXP_G2 = 1'b1;
`else
  localparam logic EXP_G2 = 1'b0;
`endif

  move_scheduler #(.SETTLE_CYCLES(16'd4), .TIMEOUT_CYCLES(24'd20)) m (
    .clock(clock), .reset(reset),
    .req_a(req_a), .move_a(move_a), .req_b(req_b), .move_b(move_b),
    .motor_done(motor_done),
    .ack_a(ack_a), .ack_b(ack_b), .err(err),
    .motor_move(motor_move), .motor_start(motor_start),
    .sensor_stable(sensor_stable), .busy(busy), .grant(grant),
    .moves_issued(moves_issued)
  );

  move_scheduler #(.SETTLE_CYCLES(16'd0), .TIMEOUT_CYCLES(24'd8)) t (
    .clock(clock), .reset(reset),
    .req_a(t_req_a), .move_a(t_move_a), .req_b(t_req_b), .move_b(t_move_b),
    .motor_done(t_motor_done),
    .ack_a(t_ack_a), .ack_b(t_ack_b), .err(t_err),
    .motor_move(t_motor_move), .motor_start(t_motor_start),
    .sensor_stable(t_sensor_stable), .busy(t_busy), .grant(t_grant),
    .moves_issued(t_moves_issued)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One successful move on instance t: request, done in WAIT, drop at ack.
  task automatic t_quick_move(input logic [4:0] code);
    t_req_a = 1'b1; t_move_a = code;
    tick();                       // c1 ISSUE
    tick();                       // c2 WAIT
    t_motor_done = 1'b1;
    tick();                       // c3 ACK
    t_motor_done = 1'b0;
    t_req_a = 1'b0;
    tick();                       // c4 GAP
    tick();                       // c5 IDLE
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0; move_a = 5'd0; move_b = 5'd0; motor_done = 1'b0;
    t_req_a = 1'b0; t_req_b = 1'b0; t_move_a = 5'd0; t_move_b = 5'd0; t_motor_done = 1'b0;
    tick();
    tick();
    chk("rst_flags_m", {ack_a, ack_b, err, motor_start, busy, grant, sensor_stable}, 32'd0);
    chk("rst_move_m", motor_move, 32'd0);
    chk("rst_cnt_m", moves_issued, 32'd0);
    chk("rst_flags_t", {t_ack_a, t_ack_b, t_err, t_motor_start, t_busy, t_grant, t_sensor_stable}, 32'd0);
    reset = 1'b0;
    tick();

    // Tie: both request together; second round with both still asserted.
    req_a = 1'b1; move_a = 5'd1; req_b = 1'b1; move_b = 5'd2;   // c0
    tick();                                                      // c1
    chk("tie_grant1", grant, 32'd0);
    chk("tie_move1", motor_move, 32'd1);
    tick();                                                      // c2
    motor_done = 1'b1;
    tick();                                                      // c3
    motor_done = 1'b0;
    repeat (4) tick();                                           // c7
    chk("tie_ack1_a", ack_a, 32'd1);
    chk("tie_ack1_b", ack_b, 32'd0);
    tick();                                                      // c8 GAP
    chk("tie_gap_busy", busy, 32'd1);
    tick();                                                      // c9 IDLE
    tick();                                                      // c10 ISSUE
    chk("tie_grant2", grant, {31'd0, EXP_G2});
    chk("tie_move2", motor_move, EXP_G2 ? 32'd2 : 32'd1);
    chk("tie_stab_issue", sensor_stable, 32'd0);
    tick();                                                      // c11
    motor_done = 1'b1;
    tick();                                                      // c12
    motor_done = 1'b0;
    repeat (4) tick();                                           // c16
    chk("tie_ack2_a", ack_a, {31'd0, ~EXP_G2});
    chk("tie_ack2_b", ack_b, {31'd0, EXP_G2});
    req_a = 1'b0; req_b = 1'b0;
    tick();                                                      // c17
    chk("tie_cnt", moves_issued, 32'd2);
    tick();                                                      // c18 IDLE

    // Basic latency: req at c0, done at c10, ack at c15.
    req_a = 1'b1; move_a = 5'd5;                                 // c0
    tick();                                                      // c1
    chk("lat_start", motor_start, 32'd1);
    chk("lat_move", motor_move, 32'd5);
    chk("lat_busy", busy, 32'd1);
    chk("lat_grant", grant, 32'd0);
    motor_done = 1'b1;                 // seen during ISSUE: must be ignored
    move_a = 5'd9;                     // change after latch: must be ignored
    tick();                                                      // c2
    motor_done = 1'b0;
    chk("lat_start_1cyc", motor_start, 32'd0);
    repeat (8) tick();                                           // c10
    motor_done = 1'b1;
    tick();                                                      // c11
    motor_done = 1'b0;
    repeat (3) tick();                                           // c14
    chk("lat_no_early_ack", ack_a, 32'd0);
    tick();                                                      // c15
    chk("lat_ack_a", ack_a, 32'd1);
    chk("lat_ack_b", ack_b, 32'd0);
    chk("lat_err", err, 32'd0);
    chk("lat_move_hold", motor_move, 32'd5);
    chk("lat_stab_ack", sensor_stable, 32'd0);
    req_a = 1'b0;
    tick();                                                      // c16
    chk("lat_ack_pulse", ack_a, 32'd0);
    chk("lat_stab", sensor_stable, 32'd1);
    chk("lat_cnt", moves_issued, 32'd3);
    tick();                                                      // c17
    chk("lat_idle_busy", busy, 32'd0);
    chk("lat_stab_hold", sensor_stable, 32'd1);

    // Invalid code from B: no motor, ack_b + err at c2.
    req_b = 1'b1; move_b = 5'd20;                                // c0
    tick();                                                      // c1
    chk("inv_start", motor_start, 32'd0);
    chk("inv_grant", grant, 32'd1);
    tick();                                                      // c2
    chk("inv_ack_b", ack_b, 32'd1);
    chk("inv_err", err, 32'd1);
    chk("inv_ack_a", ack_a, 32'd0);
    req_b = 1'b0;
    tick();                                                      // c3
    chk("inv_err_pulse", err, 32'd0);
    chk("inv_cnt", moves_issued, 32'd3);
    chk("inv_stab", sensor_stable, 32'd0);
    tick();                                                      // c4 IDLE

    // Reset during SETTLE, then a fresh request two cycles later.
    req_a = 1'b1; move_a = 5'd3;                                 // c0
    tick();                                                      // c1
    tick();                                                      // c2
    motor_done = 1'b1;
    tick();                                                      // c3 SETTLE
    motor_done = 1'b0;
    req_a = 1'b0;
    reset = 1'b1;
    tick();                                                      // c4
    reset = 1'b0;
    chk("mrst_flags", {ack_a, ack_b, err, motor_start, busy, grant, sensor_stable}, 32'd0);
    chk("mrst_move", motor_move, 32'd0);
    chk("mrst_cnt", moves_issued, 32'd0);
    tick();                                                      // c5
    chk("mrst_no_ack", {ack_a, ack_b, busy}, 32'd0);
    req_a = 1'b1; move_a = 5'd6;
    tick();                                                      // c6
    chk("mrst_start", motor_start, 32'd1);
    chk("mrst_move2", motor_move, 32'd6);
    tick();                                                      // c7
    motor_done = 1'b1;
    tick();                                                      // c8
    motor_done = 1'b0;
    repeat (4) tick();                                           // c12
    chk("mrst_ack", ack_a, 32'd1);
    req_a = 1'b0;
    tick();                                                      // c13
    chk("mrst_cnt2", moves_issued, 32'd1);
    tick();

    // Timeout on instance t: done never comes, ack + err at c10.
    t_req_a = 1'b1; t_move_a = 5'd7;                             // c0
    tick();                                                      // c1
    chk("to_start", t_motor_start, 32'd1);
    repeat (8) tick();                                           // c9
    chk("to_no_early", t_ack_a, 32'd0);
    tick();                                                      // c10
    chk("to_ack", t_ack_a, 32'd1);
    chk("to_err", t_err, 32'd1);
    t_req_a = 1'b0;
    tick();                                                      // c11
    chk("to_stab", t_sensor_stable, 32'd0);
    chk("to_cnt", t_moves_issued, 32'd0);
    chk("to_err_pulse", t_err, 32'd0);
    tick();                                                      // c12 IDLE

    // Zero settle on t: done at c2 gives ack at c3; code 17 is valid.
    t_req_a = 1'b1; t_move_a = 5'd17;                            // c0
    tick();                                                      // c1
    chk("s0_start", t_motor_start, 32'd1);
    tick();                                                      // c2
    t_motor_done = 1'b1;
    tick();                                                      // c3
    t_motor_done = 1'b0;
    chk("s0_ack", t_ack_a, 32'd1);
    chk("s0_err", t_err, 32'd0);
    t_req_a = 1'b0;
    tick();                                                      // c4
    chk("s0_stab", t_sensor_stable, 32'd1);
    chk("s0_cnt", t_moves_issued, 32'd1);
    tick();                                                      // c5 IDLE

    // Saturation: preload the counter just below the top.
    force t.r_moves = 16'hFFFE;
    tick();
    release t.r_moves;
    tick();
    chk("sat_preload", t_moves_issued, 32'h0000FFFE);
    t_quick_move(5'd0);
    chk("sat_top", t_moves_issued, 32'h0000FFFF);
    t_quick_move(5'd4);
    chk("sat_hold", t_moves_issued, 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
